debug_memory_writer: RTL and testbench

- Debug-side writer that lets the operator deposit a 32-bit word into data memory while the CPU is halted. It complements the debug/display unit's read-only memory probe.
- Operator inputs: address stepped with inc/dec; data entered nibble-by-nibble from switches; commit issues one write, then reads the location back to verify it.
- Sits beside the debug/display unit. The top level muxes WriteAddress onto the memory's debug port and ORs WriteEnable into the memory write enable while run=0.

---
 rtl/debug_memory_writer.sv | 172 +++++++++++++++++
 tb/tb_debug_memory_writer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_memory_writer.sv
// Operator-driven debug word writer with write-then-readback verify.
// Optional button debouncing when DEBUG_WRITER_DEBOUNCE_EN is defined.
module debug_memory_writer #(
  parameter int DIGIT           = 32,
  parameter int DEBUGSIZE       = 8,
  parameter int VERIFY_LATENCY  = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 run,
  input  logic [3:0]           sw,
  input  logic                 nibble,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 commit,
  input  logic [DIGIT-1:0]     ReadbackData,
  output logic                 WriteEnable,
  output logic [DEBUGSIZE-1:0] WriteAddress,
  output logic [DIGIT-1:0]     WriteData,
  output logic [3:0]           NibbleCount,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [3:0] NIBMAX = 4'(DIGIT / 4);
  localparam logic [3:0] VLAT   = 4'(VERIFY_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    VERIFY
  } state_t;

  state_t state, nextState;

  logic [3:0] raw, sync1, sync2, level, prev, pulse;
  logic       nibP, incP, decP, comP;

  assign raw = {commit, dec, inc, nibble};

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef DEBUG_WRITER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DBLAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] dbCnt [4];
  logic [3:0]    filt;

  // Level follows the synchronized input only after a full stable run
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < 4; i++) dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == filt[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] >= DBLAST) begin
          dbCnt[i] <= '0;
          filt[i]  <= sync2[i];
        end else begin
          dbCnt[i] <= dbCnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      prev  <= '0;
      pulse <= '0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end

  assign nibP = pulse[0];
  assign incP = pulse[1];
  assign decP = pulse[2];
  assign comP = pulse[3];

  logic [3:0] vcnt;
  logic       editEn, clearFlags, reject, verifyNow;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState   = state;
    WriteEnable = 1'b0;
    editEn      = 1'b0;
    clearFlags  = 1'b0;
    reject      = 1'b0;
    verifyNow   = 1'b0;
    unique case (state)
      IDLE: begin
        if (comP) begin
          if (done || error) clearFlags = 1'b1;
          else if (run)      reject     = 1'b1;
          else               nextState  = WRITE;
        end else begin
          editEn = 1'b1;
        end
      end
      WRITE: begin
        WriteEnable = 1'b1;
        nextState   = VERIFY;
      end
      VERIFY: begin
        if (vcnt <= 4'd1) begin
          verifyNow = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      WriteAddress <= '0;
      WriteData    <= '0;
      NibbleCount  <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      vcnt         <= '0;
    end else begin
      if (editEn) begin
        if (incP && !decP)      WriteAddress <= WriteAddress + 1'b1;
        else if (decP && !incP) WriteAddress <= WriteAddress - 1'b1;
        if (nibP) begin
          WriteData <= {WriteData[DIGIT-5:0], sw};
          if (NibbleCount != NIBMAX) NibbleCount <= NibbleCount + 1'b1;
        end
      end
      if (clearFlags) begin
        done  <= 1'b0;
        error <= 1'b0;
      end
      if (reject) error <= 1'b1;
      if (state == WRITE)  vcnt <= VLAT;
      if (state == VERIFY) vcnt <= vcnt - 1'b1;
      if (verifyNow) begin
        if (ReadbackData == WriteData) done  <= 1'b1;
        else                           error <= 1'b1;
        NibbleCount <= '0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_debug_memory_writer.sv
// Directed bench for debug_memory_writer with a write scoreboard
// and a small memory model providing readback.
module tb_debug_memory_writer;

  logic        CLK100MHZ = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  sw = '0;
  logic        nibble = 1'b0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic        commit = 1'b0;
  logic [31:0] ReadbackData;
  logic        WriteEnable;
  logic [7:0]  WriteAddress;
  logic [31:0] WriteData;
  logic [3:0]  NibbleCount;
  logic        busy;
  logic        done;
  logic        error;

  logic        corrupt = 1'b0;
  logic [31:0] mem [256];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 CLK100MHZ = ~CLK100MHZ;

  debug_memory_writer dut (
    .CLK100MHZ   (CLK100MHZ),
    .reset       (reset),
    .run         (run),
    .sw          (sw),
    .nibble      (nibble),
    .inc         (inc),
    .dec         (dec),
    .commit      (commit),
    .ReadbackData(ReadbackData),
    .WriteEnable (WriteEnable),
    .WriteAddress(WriteAddress),
    .WriteData   (WriteData),
    .NibbleCount (NibbleCount),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // Memory: write on strobe, read data visible the cycle after
  always @(posedge CLK100MHZ) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (WriteEnable) begin
      mem[WriteAddress] <= WriteData;
    end
  end

  assign ReadbackData = corrupt ? 32'h0 : mem[WriteAddress];

  task automatic tick(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] which, input logic [3:0] val);
    sw = val;
    {commit, dec, inc, nibble} = which;
    tick(6);
    {commit, dec, inc, nibble} = 4'b0000;
    tick(4);
  endtask

  task automatic doCommit(input logic expWrite, input logic [7:0] eAddr,
                          input logic [31:0] eData, input logic expDone,
                          input logic expErr);
    int   weCnt;
    int   weIdx;
    int   doneIdx;
    logic sawBusy;
    exp_t e;
    weCnt   = 0;
    weIdx   = -1;
    doneIdx = -1;
    sawBusy = 1'b0;
    if (expWrite) sb.push_back('{eAddr, eData});
    commit = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (i == 6) commit = 1'b0;
      if (busy) sawBusy = 1'b1;
      if (WriteEnable) begin
        weCnt++;
        weIdx = i;
        if (sb.size() == 0) begin
          chk("unexpected_write", 64'(WriteAddress), 64'hx);
        end else begin
          e = sb.pop_front();
          chk("we_addr", 64'(WriteAddress), 64'(e.addr));
          chk("we_data", 64'(WriteData), 64'(e.data));
          chk("we_busy", 64'(busy), 64'd1);
        end
      end
      if ((done || error) && doneIdx < 0) doneIdx = i;
    end
    chk("we_count", 64'(weCnt), expWrite ? 64'd1 : 64'd0);
    if (expWrite) begin
      chk("verify_delay", 64'(doneIdx - weIdx), 64'd2);
      chk("count_cleared", 64'(NibbleCount), 64'd0);
    end else begin
      chk("no_busy", 64'(sawBusy), 64'd0);
    end
    chk("done", 64'(done), 64'(expDone));
    chk("error", 64'(error), 64'(expErr));
    chk("idle", 64'(busy), 64'd0);
  endtask

  initial begin
    bit seen;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("rst_addr", 64'(WriteAddress), 64'd0);
    chk("rst_data", 64'(WriteData), 64'd0);
    chk("rst_count", 64'(NibbleCount), 64'd0);
    chk("rst_flags", 64'({WriteEnable, busy, done, error}), 64'd0);

    for (int i = 1; i <= 8; i++) press(4'b0001, 4'(i));
    chk("data8", 64'(WriteData), 64'h12345678);
    chk("count8", 64'(NibbleCount), 64'd8);
    press(4'b0001, 4'd9);
    chk("data9", 64'(WriteData), 64'h23456789);
    chk("count_sat", 64'(NibbleCount), 64'd8);

    press(4'b0100, 4'd0);
    chk("dec_wrap", 64'(WriteAddress), 64'hFF);
    press(4'b0010, 4'd0);
    chk("inc_wrap", 64'(WriteAddress), 64'h00);
    press(4'b0110, 4'd0);
    chk("inc_dec_same", 64'(WriteAddress), 64'h00);

    press(4'b0001, 4'hD);
    press(4'b0001, 4'hE);
    press(4'b0001, 4'hA);
    press(4'b0001, 4'hD);
    press(4'b0001, 4'hB);
    press(4'b0001, 4'hE);
    press(4'b0001, 4'hE);
    press(4'b0001, 4'hF);
    chk("data_deadbeef", 64'(WriteData), 64'hDEADBEEF);
    for (int i = 0; i < 16; i++) press(4'b0010, 4'd0);
    chk("addr_10", 64'(WriteAddress), 64'h10);

    doCommit(1'b1, 8'h10, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("data_kept", 64'(WriteData), 64'hDEADBEEF);
    doCommit(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);

    corrupt = 1'b1;
    doCommit(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b1);
    corrupt = 1'b0;
    doCommit(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);

    run = 1'b1;
    doCommit(1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
    doCommit(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    run = 1'b0;

    seen = 1'b0;
    commit = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (WriteEnable) seen = 1'b1;
    end
    chk("mid_we_seen", 64'(seen), 64'd1);
    tick(1);
    chk("in_verify", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_addr", 64'(WriteAddress), 64'd0);
    chk("async_data", 64'(WriteData), 64'd0);
    chk("async_flags",
        64'({WriteEnable, busy, done, error, NibbleCount}), 64'd0);
    commit = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    doCommit(1'b1, 8'h00, 32'h0, 1'b1, 1'b0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
